// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier output serializer.
package booth_pkg;

  localparam int PW_DEF    = 16;
  localparam int BW_DEF    = 8;
  localparam int DEPTH_DEF = 2;

  // Serializer phase: IDLE = nothing offered, LO/HI = which byte is on the pins.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } ser_state_t;

  // Two's-complement product as it leaves the 8x8 multiplier.
  typedef logic signed [15:0] product_t;

endpackage

// File: rtl/booth_product_serializer_if.sv
// Product-in / byte-out handshake bundle of the serializer.
interface booth_product_serializer_if
  import booth_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int BW = BW_DEF
);

  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_product;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_byte;
  logic          out_last;
  logic          busy;

  // Serializer side.
  modport slave (
    input  in_valid, in_product, out_ready,
    output in_ready, out_valid, out_byte, out_last, busy
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_byte, out_last, busy
  );

endinterface

// File: rtl/booth_prod_fifo.sv
// Synchronous FIFO for products; pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter.
module booth_prod_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Advance write/read pointers on accepted push/pop; both may occur together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // edge reading the pre-edge values, independent of statement order.
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Store the incoming product at the write index.
  // NOTE: storage is deliberately left out of reset; the pointers alone decide
  // which entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/booth_product_serializer.sv
// Output stage of the 8x8 Booth multiplier: queues 16-bit products and drives
// each one out as two byte beats, low byte first, with AXI-style stable beats.
module booth_product_serializer
  import booth_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int BW    = BW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic                        clk,
  input logic                        rst,
  booth_product_serializer_if.slave  bus
);

  // The low half of a popped product goes straight into the output register,
  // so only the high half has to wait in the holding register.
  localparam int HW = PW - BW;

  ser_state_t    state_q, state_d;
  logic [HW-1:0] hold_hi_q, hold_hi_d;
  logic [BW-1:0] out_byte_q, out_byte_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;

  logic [PW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // in_ready is a function of FIFO state only, never of out_ready.
  assign push = bus.in_valid & ~fifo_full;

  booth_prod_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (bus.in_product),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: a beat advances only when the consumer takes it.
  always_comb begin
    // NOTE: default first, so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty)   state_d = LO;
      LO:      if (bus.out_ready) state_d = HI;
      HI:      if (bus.out_ready) state_d = fifo_empty ? IDLE : LO;
      default:                    state_d = IDLE;
    endcase
  end

  // Output/datapath logic: pop, load the holding register, pick the next beat.
  always_comb begin
    pop         = 1'b0;
    hold_hi_d   = hold_hi_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          hold_hi_d   = head[PW-1:BW];
          out_byte_d  = head[BW-1:0];
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
        end
      end
      LO: begin
        if (bus.out_ready) begin
          out_byte_d = hold_hi_q;
          out_last_d = 1'b1;
        end
      end
      HI: begin
        if (bus.out_ready) begin
          if (!fifo_empty) begin
            // Chain straight into the next product: no idle bubble.
            pop         = 1'b1;
            hold_hi_d   = head[PW-1:BW];
            out_byte_d  = head[BW-1:0];
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  // Holding and output registers; reset discards any pending beat at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_hi_q   <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      hold_hi_q   <= hold_hi_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = ~fifo_full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = ~fifo_empty | (state_q != IDLE);

endmodule
